// File: rtl/servo_ramp_pwm.sv
// Servo PWM output stage: ramps the commanded pulse width toward the open/closed
// target by at most STEP cycles per frame and reports motion status.
module servo_ramp_pwm #(
  parameter int PERIOD_CYCLES = 500_000,
  parameter int PULSE_MIN     = 25_000,
  parameter int PULSE_MAX     = 50_000,
  parameter int STEP          = 500,
  parameter int PERIOD_W      = 19,
  parameter int PULSE_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               open_req,
  input  logic               enable,
  output logic               servo_pwm,
  output logic [PULSE_W-1:0] pulse_width,
  output logic               frame_tick,
  output logic               moving,
  output logic               at_target
);

  typedef enum logic [1:0] {
    CLOSED,
    OPENING,
    OPEN,
    CLOSING
  } state_t;

  localparam logic [PERIOD_W-1:0] CNT_LAST     = PERIOD_W'(PERIOD_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] CNT_PRE_LAST = PERIOD_W'(PERIOD_CYCLES - 2);
  localparam logic [PULSE_W:0]    MIN_X        = (PULSE_W + 1)'(PULSE_MIN);
  localparam logic [PULSE_W:0]    MAX_X        = (PULSE_W + 1)'(PULSE_MAX);
  localparam logic [PULSE_W:0]    STEP_X       = (PULSE_W + 1)'(STEP);

  logic [PERIOD_W-1:0] period_cnt;
  logic                target_open;
  state_t              state;
  state_t              state_next;
  logic [PULSE_W:0]    width_x;
  logic [PULSE_W:0]    target_x;
  logic [PULSE_W:0]    width_up;
  logic [PULSE_W:0]    width_dn;
  logic [PULSE_W:0]    width_next;

  // frame_tick is registered one cycle early so it is high while period_cnt is at the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      frame_tick <= 1'b0;
    end else begin
      period_cnt <= (period_cnt == CNT_LAST) ? '0 : period_cnt + 1'b1;
      frame_tick <= (period_cnt == CNT_PRE_LAST);
    end
  end

  // One extra bit keeps width+STEP from wrapping; the subtract floors at zero before clamping.
  always_comb begin
    target_x   = open_req ? MAX_X : MIN_X;
    width_x    = {1'b0, pulse_width};
    width_up   = width_x + STEP_X;
    width_dn   = (width_x >= STEP_X) ? (width_x - STEP_X) : '0;
    width_next = width_x;
    if (width_x < target_x) begin
      width_next = (width_up > target_x) ? target_x : width_up;
    end else if (width_x > target_x) begin
      width_next = (width_dn < target_x) ? target_x : width_dn;
    end
  end

  always_comb begin
    state_next = state;
    if (frame_tick && enable) begin
      if (open_req) begin
        state_next = (width_next == MAX_X) ? OPEN : OPENING;
      end else begin
        state_next = (width_next == MIN_X) ? CLOSED : CLOSING;
      end
    end
  end

  // Width and target only change on the last cycle of a frame, so every pulse is whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_width <= PULSE_W'(PULSE_MIN);
      target_open <= 1'b0;
      state       <= CLOSED;
    end else begin
      state <= state_next;
      if (frame_tick) begin
        target_open <= open_req;
        if (enable) begin
          pulse_width <= width_next[PULSE_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      servo_pwm <= 1'b0;
    end else begin
      servo_pwm <= enable & (int'(period_cnt) < int'(pulse_width));
    end
  end

  always_comb begin
    moving    = ({1'b0, pulse_width} != (target_open ? MAX_X : MIN_X));
    at_target = ~moving;
  end

endmodule

// File: tb/tb_servo_ramp_pwm.sv
// Bench for servo_ramp_pwm: two instances (STEP 4 and 7) checked every cycle against
// an arithmetic model, plus literal per-frame high-time expectations.
module tb_servo_ramp_pwm;

  localparam int P    = 100;
  localparam int WMIN = 10;
  localparam int WMAX = 30;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      open_req;
  logic [1:0]      enable;
  wire  [1:0]      servo_pwm;
  wire  [1:0]      frame_tick;
  wire  [1:0]      moving;
  wire  [1:0]      at_target;
  wire  [1:0][7:0] pulse_width;

  int checks = 0;
  int errors = 0;

  int   m_cyc    [2];
  int   m_width  [2];
  int   m_target [2];
  logic m_pwm    [2];

  int pat_open [10];
  int pat_en   [10];
  int exp_hi   [10];
  int exp_w    [10];

  always #5 clk = ~clk;

  servo_ramp_pwm #(
    .PERIOD_CYCLES(P), .PULSE_MIN(WMIN), .PULSE_MAX(WMAX), .STEP(4),
    .PERIOD_W(7), .PULSE_W(8)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .open_req(open_req[0]), .enable(enable[0]),
    .servo_pwm(servo_pwm[0]), .pulse_width(pulse_width[0]),
    .frame_tick(frame_tick[0]), .moving(moving[0]), .at_target(at_target[0])
  );

  servo_ramp_pwm #(
    .PERIOD_CYCLES(P), .PULSE_MIN(WMIN), .PULSE_MAX(WMAX), .STEP(7),
    .PERIOD_W(7), .PULSE_W(8)
  ) u_dut7 (
    .clk(clk), .rst_n(rst_n), .open_req(open_req[1]), .enable(enable[1]),
    .servo_pwm(servo_pwm[1]), .pulse_width(pulse_width[1]),
    .frame_tick(frame_tick[1]), .moving(moving[1]), .at_target(at_target[1])
  );

  function automatic int step_of(int i);
    return (i == 0) ? 4 : 7;
  endfunction

  function automatic int ramp(int w, int t, int s);
    if (w < t) return (w + s > t) ? t : w + s;
    if (w > t) return (w - s < t) ? t : w - s;
    return w;
  endfunction

  // Model: position in frame is cycles since reset mod P; width moves once per frame end.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cyc[i]    <= 0;
        m_width[i]  <= WMIN;
        m_target[i] <= WMIN;
        m_pwm[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_pwm[i] <= enable[i] && ((m_cyc[i] % P) < m_width[i]);
        if (m_cyc[i] % P == P - 1) begin
          m_target[i] <= open_req[i] ? WMAX : WMIN;
          if (enable[i])
            m_width[i] <= ramp(m_width[i], open_req[i] ? WMAX : WMIN, step_of(i));
        end
        m_cyc[i] <= m_cyc[i] + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int inst, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s inst%0d actual=%0d expected=%0d at %0t", name, inst, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic open, input logic en);
    open_req[inst] = open;
    enable[inst]   = en;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput("frame_tick", i, int'(frame_tick[i]), int'((m_cyc[i] % P) == P - 1));
        checkOutput("pulse_width", i, int'(pulse_width[i]), m_width[i]);
        checkOutput("servo_pwm", i, int'(servo_pwm[i]), int'(m_pwm[i]));
        checkOutput("moving", i, int'(moving[i]), int'(m_width[i] != m_target[i]));
        checkOutput("at_target", i, int'(at_target[i]), int'(m_width[i] == m_target[i]));
        checkOutput("width_range", i,
                    int'(pulse_width[i] >= 8'(WMIN) && pulse_width[i] <= 8'(WMAX)), 1);
      end
    end
  end

  task automatic wait_tick(input int inst);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_tick[inst] !== 1'b1 && k < 2 * P);
    if (frame_tick[inst] !== 1'b1) checkOutput("tick_timeout", inst, 0, 1);
  endtask

  // Frame f's inputs are applied on the tick cycle that starts it, then its high time is counted.
  task automatic run_frames(input int inst, input string name, input int n);
    int hi;
    wait_tick(inst);
    for (int f = 0; f < n; f++) begin
      applyStimulus(inst, pat_open[f] != 0, pat_en[f] != 0);
      hi = 0;
      repeat (P) begin
        @(negedge clk);
        hi += int'(servo_pwm[inst]);
      end
      checkOutput({name, "_high"}, inst, hi, exp_hi[f]);
      checkOutput({name, "_width"}, inst, int'(pulse_width[inst]), exp_w[f]);
      checkOutput({name, "_period"}, inst, int'(frame_tick[inst]), 1);
    end
  endtask

  task automatic set_pattern(input int f, input int op, input int en, input int hi, input int w);
    pat_open[f] = op;
    pat_en[f]   = en;
    exp_hi[f]   = hi;
    exp_w[f]    = w;
  endtask

  initial begin
    int k;
    int hi;
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_pwm", i, int'(servo_pwm[i]), 0);
      checkOutput("rst_width", i, int'(pulse_width[i]), WMIN);
      checkOutput("rst_tick", i, int'(frame_tick[i]), 0);
      checkOutput("rst_moving", i, int'(moving[i]), 0);
      checkOutput("rst_at_target", i, int'(at_target[i]), 1);
    end
    rst_n = 1'b1;

    set_pattern(0, 0, 1, 10, 10);
    set_pattern(1, 0, 1, 10, 10);
    run_frames(0, "idle", 2);

    set_pattern(0, 1, 1, 14, 14);
    set_pattern(1, 1, 1, 18, 18);
    set_pattern(2, 1, 1, 22, 22);
    set_pattern(3, 1, 1, 26, 26);
    set_pattern(4, 1, 1, 30, 30);
    set_pattern(5, 1, 1, 30, 30);
    run_frames(0, "open", 6);

    set_pattern(0, 0, 1, 26, 26);
    set_pattern(1, 0, 1, 22, 22);
    set_pattern(2, 0, 1, 18, 18);
    set_pattern(3, 0, 1, 14, 14);
    set_pattern(4, 0, 1, 10, 10);
    set_pattern(5, 0, 1, 10, 10);
    run_frames(0, "close", 6);

    set_pattern(0, 1, 1, 14, 14);
    set_pattern(1, 1, 1, 18, 18);
    set_pattern(2, 0, 1, 14, 14);
    set_pattern(3, 0, 1, 10, 10);
    set_pattern(4, 0, 1, 10, 10);
    run_frames(0, "reverse", 5);

    set_pattern(0, 1, 1, 14, 14);
    set_pattern(1, 1, 1, 18, 18);
    set_pattern(2, 1, 1, 22, 22);
    set_pattern(3, 1, 0, 0, 22);
    set_pattern(4, 1, 0, 0, 22);
    set_pattern(5, 1, 0, 0, 22);
    set_pattern(6, 1, 1, 26, 26);
    set_pattern(7, 1, 1, 30, 30);
    run_frames(0, "gate", 8);

    // Reset asserted between clock edges while the width-30 pulse is high.
    wait_tick(0);
    repeat (6) @(negedge clk);
    checkOutput("pre_reset_pwm", 0, int'(servo_pwm[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_pwm", 0, int'(servo_pwm[0]), 0);
    checkOutput("async_width", 0, int'(pulse_width[0]), WMIN);
    checkOutput("async_at_target", 0, int'(at_target[0]), 1);
    applyStimulus(0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k  = 0;
    hi = 0;
    do begin
      @(negedge clk);
      k++;
      if (frame_tick[0] === 1'b1) break;
      hi += int'(servo_pwm[0]);
    end while (k < 2 * P);
    checkOutput("first_tick_delay", 0, k, P - 1);
    checkOutput("first_frame_high", 0, hi, WMIN);

    wait_tick(1);
    repeat (30) @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b1);
    set_pattern(0, 0, 1, 10, 10);
    set_pattern(1, 0, 1, 10, 10);
    run_frames(1, "glitch", 2);

    set_pattern(0, 1, 1, 17, 17);
    set_pattern(1, 1, 1, 24, 24);
    set_pattern(2, 1, 1, 30, 30);
    set_pattern(3, 1, 1, 30, 30);
    run_frames(1, "step7", 4);

    // Random phase: sparse toggles land both mid-frame and on tick cycles.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 149) == 0) open_req[i] = ~open_req[i];
        if ($urandom_range(0, 299) == 0) enable[i] = ~enable[i];
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
